mux_n_stream: RTL
=================

# mux_n_stream

Parametrised successor to the registered 3-input operand mux: selects one of NUM_IN WIDTH-bit sources and registers it behind a valid/ready handshake with a two-entry skid buffer. It sits between the register-file/immediate/forwarding sources and the ALU operand stage, so that back-pressure from a stalled downstream stage never drops or duplicates an operand. It also handles out-of-range selects deterministically and supports a pipeline flush.

## Interface
Parameters:
- WIDTH, 16, data width per source
- NUM_IN, 3, number of sources (2..16)
- SEL_W, 2, select width; ceil(log2(NUM_IN)) ≤ SEL_W ≤ 4

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_data  input  NUM_IN*WIDTH  packed sources; source k at bits [k*WIDTH +: WIDTH], source 0 (in1) in the LSBs
- sel  input  SEL_W  source index, sampled with the transfer
- in_valid  input  1  sel/in_data valid this cycle
- in_ready  output  1  block can accept; registered, equals !skid_valid
- flush  input  1  synchronous discard of all buffered entries
- out_data  output  WIDTH  selected data of head entry
- out_sel  output  SEL_W  sel value that produced out_data
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry this cycle
- bad_sel  output  1  sticky: some accepted sel was ≥ NUM_IN

## Operation
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Captured word = in_data source[sel] if sel < NUM_IN, else all-zero. Out-of-range sel is still a legal transfer; it sets bad_sel.
- Two entries: M (head, drives outputs) and S (skid). S is filled only while M is stalled.
- Per-edge update, with Mv/Sv as the valid bits:
  - !Mv: if accept, M ← input.
  - Mv & !Sv & drain: M ← input if accept, else Mv ← 0.
  - Mv & !Sv & !drain: if accept, S ← input.
  - Mv & Sv & drain: M ← S, Sv ← 0. No accept is possible because in_ready = 0.
  - Mv & Sv & !drain: hold.
- flush has priority over everything: Mv ← 0, Sv ← 0, and in_ready = 1 next cycle. An input accepted in the flush cycle is discarded, and so is a drain in that cycle (the downstream still sees that transfer). bad_sel is not cleared by flush.
- out_data/out_sel hold their last value when out_valid = 0. Only valid bits are cleared.
- bad_sel is cleared only by reset.
- Input sel/in_data may change freely while in_valid = 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_sel 0, in_ready 1, bad_sel 0, Mv = Sv = 0.
- Reset is asynchronous: asserting it mid-transfer clears all state at once, and any buffered entries are lost.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N, i.e. one cycle, the same as the legacy mux.
- Throughput: one word per cycle while out_ready = 1.
- in_ready deasserts the cycle after S fills, and reasserts the cycle after S empties. It never depends combinationally on out_ready.
- bad_sel rises after the edge that accepts the offending sel.
- Order is strictly FIFO: S always moves to M before any new input reaches M.

## Test plan
- Reset, then 3-source 16-bit defaults: in_data sources = 0x1111/0x2222/0x3333, sel = 0,1,2 back to back, out_ready = 1 → out_data 0x1111, 0x2222, 0x3333 on three consecutive cycles, each one cycle after accept; in_ready stays 1; bad_sel stays 0.
- Back-pressure: stream A, B, C with out_ready = 0 after A is accepted → B goes to S, in_ready drops; C is held upstream; out_data stays A. Raise out_ready → A, B, C delivered in order with none lost or duplicated.
- Out-of-range: sel = 3 with NUM_IN = 3 → out_data 0x0000, out_sel 3, bad_sel = 1. bad_sel persists through subsequent valid transfers and through a flush.
- Flush: fill M and S (out_ready = 0), assert flush with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, and the flushed input is never output.
- Async reset mid-stream: assert reset between clock edges while M and S are full → out_valid, in_ready, out_data and bad_sel reach their reset values without a clock edge.
- Parameter sweep: WIDTH = 32, NUM_IN = 5, SEL_W = 3 → each source 0..4 selectable; sel = 5..7 give zero and set bad_sel.

Source files
------------

// File: rtl/mux_n_stream.sv
// mux_n_stream: selects one of NUM_IN WIDTH-bit sources and delivers it through a
// valid/ready handshake. Two entries (head M, skid S) absorb downstream stalls, so
// no operand is dropped or duplicated.
//
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-high reset
//   in_data, sel, in_valid - packed sources (source k at [k*WIDTH +: WIDTH]) and index
//   in_ready               - registered; high while the skid entry is empty
//   flush                  - synchronous discard of both buffered entries
//   out_data, out_sel      - head entry payload; held while out_valid is low
//   out_valid, out_ready   - head entry handshake
//   bad_sel                - sticky flag: an accepted sel was >= NUM_IN
module mux_n_stream #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    bad_sel
);

  // Head (M) and skid (S) entries
  logic              m_valid_q, m_valid_d;
  logic [WIDTH-1:0]  m_data_q,  m_data_d;
  logic [SEL_W-1:0]  m_sel_q,   m_sel_d;
  logic              s_valid_q, s_valid_d;
  logic [WIDTH-1:0]  s_data_q,  s_data_d;
  logic [SEL_W-1:0]  s_sel_q,   s_sel_d;
  logic              in_ready_q, in_ready_d;
  logic              bad_sel_q,  bad_sel_d;

  logic [WIDTH-1:0]  in_word_c;
  logic              sel_bad_c;
  logic              accept_c;
  logic              drain_c;

  // Source select; an out-of-range index yields an all-zero word
  always_comb begin
    in_word_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) in_word_c = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign sel_bad_c = (32'(sel) >= NUM_IN);
  assign accept_c  = in_valid & in_ready_q;
  assign drain_c   = m_valid_q & out_ready;

  // Next-state for the two-entry skid buffer
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sel_d   = m_sel_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_sel_d   = s_sel_q;
    bad_sel_d = bad_sel_q | (accept_c & sel_bad_c);

    if (flush) begin
      // Only valid bits are cleared; payload registers keep their last value
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q) begin
      if (accept_c) begin
        m_valid_d = 1'b1;
        m_data_d  = in_word_c;
        m_sel_d   = sel;
      end
    end else if (!s_valid_q) begin
      if (drain_c) begin
        m_valid_d = accept_c;
        if (accept_c) begin
          m_data_d = in_word_c;
          m_sel_d  = sel;
        end
      end else if (accept_c) begin
        s_valid_d = 1'b1;
        s_data_d  = in_word_c;
        s_sel_d   = sel;
      end
    end else if (drain_c) begin
      // Skid moves to head before any new input (in_ready is low here)
      m_data_d  = s_data_q;
      m_sel_d   = s_sel_q;
      s_valid_d = 1'b0;
    end

    in_ready_d = ~s_valid_d;
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_sel_q    <= '0;
      s_valid_q  <= 1'b0;
      s_data_q   <= '0;
      s_sel_q    <= '0;
      in_ready_q <= 1'b1;
      bad_sel_q  <= 1'b0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_sel_q    <= m_sel_d;
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      s_sel_q    <= s_sel_d;
      in_ready_q <= in_ready_d;
      bad_sel_q  <= bad_sel_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = m_data_q;
  assign out_sel   = m_sel_q;
  assign out_valid = m_valid_q;
  assign bad_sel   = bad_sel_q;

endmodule
